imem_boot_ctrl: RTL and testbench

- Boot and arbitration controller for the fetch-stage instruction memory (single-port, combinational read, synchronous write).
- After reset it owns the memory and streams a program in from a loader port while holding the core. It then hands the memory to the fetch path and pulses a PC-clear.
- Guards fetches against out-of-range and misaligned addresses.
- Supports a run-time reload request that re-enters the load phase.

---
 rtl/imem_ctrl_pkg.sv | 13 +
 rtl/imem_fetch_guard.sv | 22 ++
 rtl/imem_boot_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

endpackage

// File: rtl/imem_fetch_guard.sv
// Fetch address guard: flags misaligned or beyond-image PCs and substitutes a NOP.
// Purely combinational, zero latency; no backpressure.
module imem_fetch_guard #(
    parameter int               XLEN     = imem_ctrl_pkg::XLEN_DEF,
    parameter int               AW       = 6,
    parameter logic [XLEN-1:0]  NOP_INST = imem_ctrl_pkg::NOP_INST
) (
    input  logic [XLEN-1:0] fetch_addr_i,
    input  logic [AW:0]     load_count_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] inst_o,
    output logic            fault_o
);

    logic [XLEN-3:0] word_idx;

    // Full upper address is compared so a large PC can never alias into the image.
    assign word_idx = fetch_addr_i[XLEN-1:2];
    assign fault_o  = (fetch_addr_i[1:0] != 2'b00) || (word_idx >= (XLEN-2)'(load_count_i));
    assign inst_o   = fault_o ? NOP_INST : mem_rdata_i;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/arbitration controller for the fetch instruction memory: loads an image, then hands off to fetch.
// Fetch path zero latency; loader ready only in LOAD. Optional checksum check under IMEM_CKSUM_EN.
module imem_boot_ctrl #(
    parameter int               XLEN     = imem_ctrl_pkg::XLEN_DEF,
    parameter int               DEPTH    = 40,
    parameter int               AW       = $clog2(DEPTH),
    parameter logic [XLEN-1:0]  NOP_INST = imem_ctrl_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    input  logic            reload_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic [XLEN-1:0] fetch_inst,
    output logic            fetch_fault,
    output logic            cpu_hold,
    output logic            pc_clear,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [AW:0]     load_count,
`ifdef IMEM_CKSUM_EN
    input  logic [XLEN-1:0] cksum_exp,
    output logic [XLEN-1:0] cksum_o,
`endif
    output logic [1:0]      state_o
);

    import imem_ctrl_pkg::*;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH-1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e          state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            pc_clear_q, pc_clear_d;
    logic            xfer;
    logic            cksum_bad;
    logic [XLEN-1:0] guard_inst;
    logic            guard_fault;

`ifdef IMEM_CKSUM_EN
    logic [XLEN-1:0] cksum_q, cksum_d;
    assign cksum_bad = ld_last && ((cksum_q + ld_data) != cksum_exp);
    assign cksum_o   = cksum_q;
`else
    assign cksum_bad = 1'b0;
`endif

    imem_fetch_guard #(
        .XLEN     (XLEN),
        .AW       (AW),
        .NOP_INST (NOP_INST)
    ) u_guard (
        .fetch_addr_i (fetch_addr),
        .load_count_i (cnt_q),
        .mem_rdata_i  (mem_rdata),
        .inst_o       (guard_inst),
        .fault_o      (guard_fault)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_clear_d  = 1'b0;
        ld_ready    = 1'b0;
        xfer        = 1'b0;
        cpu_hold    = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = fetch_addr[AW+1:2];
        fetch_inst  = NOP_INST;
        fetch_fault = 1'b0;
`ifdef IMEM_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        case (state_q)
            ST_LOAD: begin
                // Ready is held low while reset is asserted, even though the state reads LOAD.
                ld_ready = reset;
                xfer     = ld_valid && reset;
                mem_we   = xfer;
                mem_addr = cnt_q[AW-1:0];
                if (xfer) begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef IMEM_CKSUM_EN
                    cksum_d = cksum_q + ld_data;
`endif
                    if (ld_last || (cnt_q == LAST_IDX)) begin
                        if (cksum_bad) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d    = ST_RUN;
                            pc_clear_d = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                cpu_hold    = 1'b0;
                fetch_inst  = guard_inst;
                fetch_fault = guard_fault;
                if (reload_req) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef IMEM_CKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            ST_ERR: begin
                if (reload_req) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef IMEM_CKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            pc_clear_q <= 1'b0;
`ifdef IMEM_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_clear_q <= pc_clear_d;
`ifdef IMEM_CKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    assign mem_wdata  = ld_data;
    assign load_count = cnt_q;
    assign pc_clear   = pc_clear_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with an external combinational-read memory model.
module tb_imem_boot_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_last, reload_req;
    logic [31:0] ld_data, fetch_addr, fetch_inst, mem_wdata, mem_rdata;
    logic        fetch_fault, cpu_hold, pc_clear, mem_we;
    logic [5:0]  mem_addr;
    logic [6:0]  load_count;
    logic [1:0]  state_o;
`ifdef IMEM_CKSUM_EN
    logic [31:0] cksum_exp, cksum_o;
`endif

    logic [31:0] mem [0:63];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .reload_req  (reload_req),
        .fetch_addr  (fetch_addr),
        .fetch_inst  (fetch_inst),
        .fetch_fault (fetch_fault),
        .cpu_hold    (cpu_hold),
        .pc_clear    (pc_clear),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .load_count  (load_count),
`ifdef IMEM_CKSUM_EN
        .cksum_exp   (cksum_exp),
        .cksum_o     (cksum_o),
`endif
        .state_o     (state_o)
    );

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        last;
        logic        rel;
        logic [31:0] faddr;
        logic        e_rdy;
        logic        e_we;
        logic [5:0]  e_addr;
        logic        e_hold;
        logic        e_pc;
        logic [1:0]  e_st;
        logic [6:0]  e_cnt;
        logic [31:0] e_inst;
        logic        e_flt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] dat, input logic last,
                         input logic rel, input logic [31:0] faddr);
        @(negedge clk);
        ld_valid = vld; ld_data = dat; ld_last = last; reload_req = rel; fetch_addr = faddr;
        #1;
    endtask

    task automatic load_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) drive(1'b1, base + 32'(i), (i == n-1), 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b0; ld_valid = 1'b1; ld_data = 32'hDEAD; ld_last = 1'b0;
        reload_req = 1'b0; fetch_addr = 32'h0;
`ifdef IMEM_CKSUM_EN
        cksum_exp = 32'd7;
`endif
        // Reset state, with a loader word already offered.
        #7;
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_we",    32'(mem_we),   32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_pcclr", 32'(pc_clear), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_state", 32'(state_o),  32'd0);
        chk("rst_cnt",   32'(load_count), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        reset = 1'b1;

        //         vld dat     last rel faddr          rdy we addr hold pc st cnt inst         flt
        vq.push_back('{0, 32'h00, 0, 0, 32'h00,        1, 0, 0, 1, 0, 0, 0, NOP,          0});
        vq.push_back('{1, 32'h11, 0, 0, 32'h00,        1, 1, 0, 1, 0, 0, 0, NOP,          0});
        vq.push_back('{1, 32'h12, 0, 0, 32'h00,        1, 1, 1, 1, 0, 0, 1, NOP,          0});
        vq.push_back('{0, 32'h00, 1, 0, 32'h00,        1, 0, 2, 1, 0, 0, 2, NOP,          0});
        vq.push_back('{1, 32'h13, 0, 0, 32'h00,        1, 1, 2, 1, 0, 0, 2, NOP,          0});
        vq.push_back('{1, 32'h14, 0, 1, 32'h00,        1, 1, 3, 1, 0, 0, 3, NOP,          0});
        vq.push_back('{1, 32'h15, 1, 0, 32'h00,        1, 1, 4, 1, 0, 0, 4, NOP,          0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h10,        0, 0, 4, 0, 1, 1, 5, 32'h15,       0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h14,        0, 0, 5, 0, 0, 1, 5, NOP,          1});
        vq.push_back('{0, 32'h00, 0, 0, 32'h06,        0, 0, 1, 0, 0, 1, 5, NOP,          1});
        vq.push_back('{0, 32'h00, 0, 0, 32'h00,        0, 0, 0, 0, 0, 1, 5, 32'h11,       0});
        vq.push_back('{1, 32'hEE, 0, 0, 32'h04,        0, 0, 1, 0, 0, 1, 5, 32'h12,       0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h08,        0, 0, 2, 0, 0, 1, 5, 32'h13,       0});
        vq.push_back('{0, 32'h00, 0, 1, 32'h0C,        0, 0, 3, 0, 0, 1, 5, 32'h14,       0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h10,        1, 0, 0, 1, 0, 0, 0, NOP,          0});
        vq.push_back('{1, 32'hA1, 0, 0, 32'h10,        1, 1, 0, 1, 0, 0, 0, NOP,          0});
        vq.push_back('{1, 32'hA2, 1, 0, 32'h10,        1, 1, 1, 1, 0, 0, 1, NOP,          0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h04,        0, 0, 1, 0, 1, 1, 2, 32'hA2,       0});
        vq.push_back('{0, 32'h00, 0, 0, 32'h08,        0, 0, 2, 0, 0, 1, 2, NOP,          1});
        vq.push_back('{0, 32'h00, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 2, NOP,          1});

        foreach (vq[i]) begin
            drive(vq[i].vld, vq[i].dat, vq[i].last, vq[i].rel, vq[i].faddr);
            chk($sformatf("v%0d_rdy", i),   32'(ld_ready),    32'(vq[i].e_rdy));
            chk($sformatf("v%0d_we", i),    32'(mem_we),      32'(vq[i].e_we));
            chk($sformatf("v%0d_addr", i),  32'(mem_addr),    32'(vq[i].e_addr));
            chk($sformatf("v%0d_hold", i),  32'(cpu_hold),    32'(vq[i].e_hold));
            chk($sformatf("v%0d_pcclr", i), 32'(pc_clear),    32'(vq[i].e_pc));
            chk($sformatf("v%0d_state", i), 32'(state_o),     32'(vq[i].e_st));
            chk($sformatf("v%0d_cnt", i),   32'(load_count),  32'(vq[i].e_cnt));
            chk($sformatf("v%0d_inst", i),  fetch_inst,       vq[i].e_inst);
            chk($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(vq[i].e_flt));
        end

        // Full-depth image without ld_last: auto hand-off after the 40th word.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0);
            chk($sformatf("full_rdy%0d", i), 32'(ld_ready), 32'd1);
            chk($sformatf("full_cnt%0d", i), 32'(load_count), 32'(i));
        end
        drive(1'b1, 32'h999, 1'b0, 1'b0, 32'h9C);
        chk("full_state", 32'(state_o), 32'd1);
        chk("full_cnt",   32'(load_count), 32'd40);
        chk("full_pcclr", 32'(pc_clear), 32'd1);
        chk("full_rdy",   32'(ld_ready), 32'd0);
        chk("full_we",    32'(mem_we), 32'd0);
        chk("full_inst39", fetch_inst, 32'h127);
        drive(1'b1, 32'h999, 1'b0, 1'b0, 32'hA0);
        chk("full_pcclr2", 32'(pc_clear), 32'd0);
        chk("full_cnt2",   32'(load_count), 32'd40);
        chk("full_fault40", 32'(fetch_fault), 32'd1);
        chk("full_inst40",  fetch_inst, NOP);

        // Async reset in the middle of a reload.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h201, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h202, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h203, 1'b0, 1'b0, 32'h0);
        #1;
        chk("mid_cnt_before", 32'(load_count), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_cnt",   32'(load_count), 32'd0);
        chk("mid_rst_rdy",   32'(ld_ready), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        reset = 1'b1;

`ifdef IMEM_CKSUM_EN
        cksum_exp = 32'd7;
        load_words(3, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ck_bad_state", 32'(state_o), 32'd2);
        chk("ck_bad_pcclr", 32'(pc_clear), 32'd0);
        chk("ck_bad_hold",  32'(cpu_hold), 32'd1);
        chk("ck_bad_rdy",   32'(ld_ready), 32'd0);
        chk("ck_bad_inst",  fetch_inst, NOP);
        chk("ck_bad_sum",   cksum_o, 32'd6);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("ck_reload_state", 32'(state_o), 32'd0);
        chk("ck_reload_sum",   cksum_o, 32'd0);
        cksum_exp = 32'd6;
        load_words(3, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h8);
        chk("ck_ok_state", 32'(state_o), 32'd1);
        chk("ck_ok_pcclr", 32'(pc_clear), 32'd1);
        chk("ck_ok_cnt",   32'(load_count), 32'd3);
        chk("ck_ok_inst",  fetch_inst, 32'd3);
`else
        load_words(3, 32'h301);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h8);
        chk("rl_state", 32'(state_o), 32'd1);
        chk("rl_pcclr", 32'(pc_clear), 32'd1);
        chk("rl_cnt",   32'(load_count), 32'd3);
        chk("rl_inst",  fetch_inst, 32'h303);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
